// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment scanner: blank pattern,
// scanner state encoding and the active-low hex glyph table.
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_e;

    // Segment order is g..a in bits [6:0], 0 = segment lit.
    localparam logic [6:0] SEG_HEX_0 = 7'b1000000;
    localparam logic [6:0] SEG_HEX_1 = 7'b1111001;
    localparam logic [6:0] SEG_HEX_2 = 7'b0100100;
    localparam logic [6:0] SEG_HEX_3 = 7'b0110000;
    localparam logic [6:0] SEG_HEX_4 = 7'b0011001;
    localparam logic [6:0] SEG_HEX_5 = 7'b0010010;
    localparam logic [6:0] SEG_HEX_6 = 7'b0000010;
    localparam logic [6:0] SEG_HEX_7 = 7'b1111000;
    localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
    localparam logic [6:0] SEG_HEX_9 = 7'b0010000;
    localparam logic [6:0] SEG_HEX_A = 7'b0001000;
    localparam logic [6:0] SEG_HEX_B = 7'b0000011;
    localparam logic [6:0] SEG_HEX_C = 7'b1000110;
    localparam logic [6:0] SEG_HEX_D = 7'b0100001;
    localparam logic [6:0] SEG_HEX_E = 7'b0000110;
    localparam logic [6:0] SEG_HEX_F = 7'b0001110;

    localparam logic [15:0][6:0] SEG_HEX_LUT = {
        SEG_HEX_F, SEG_HEX_E, SEG_HEX_D, SEG_HEX_C,
        SEG_HEX_B, SEG_HEX_A, SEG_HEX_9, SEG_HEX_8,
        SEG_HEX_7, SEG_HEX_6, SEG_HEX_5, SEG_HEX_4,
        SEG_HEX_3, SEG_HEX_2, SEG_HEX_1, SEG_HEX_0
    };

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment glyph.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_n_o
);

    assign seg_n_o = SEG_HEX_LUT[hex_i];

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed common-anode hex display driver with blank-phase anti-ghosting,
// frame-boundary data commit and optional leading-zero suppression.
module seven_segment_scanner
    import seg_pkg::*;
#(
    parameter int unsigned N_DIGITS     = 4,
    parameter int unsigned SLOT_CYCLES  = 50000,
    parameter int unsigned BLANK_CYCLES = 500,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*N_DIGITS-1:0] value,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic                  lz_en,
    input  logic                  load,
    output logic [N_DIGITS-1:0]   an_n,
    output logic [6:0]            seg_n,
    output logic                  dp_n,
    output logic                  frame_tick,
    output scan_state_e           dbg_state
);

    localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    scan_state_e           state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;

    logic [4*N_DIGITS-1:0] pend_val_q, pend_val_d;
    logic [N_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic                  pend_lz_q, pend_lz_d;
    logic                  pend_flag_q, pend_flag_d;

    logic [4*N_DIGITS-1:0] disp_val_q, disp_val_d;
    logic [N_DIGITS-1:0]   disp_dp_q, disp_dp_d;
    logic                  disp_lz_q, disp_lz_d;

    logic [N_DIGITS-1:0]   an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic                  tick_q, tick_d;

    logic                  slot_end;
    logic                  wrap;
    logic [3:0]            cur_digit;
    logic                  cur_dp;
    logic [N_DIGITS-1:0]   an_sel;
    logic                  suppress;
    logic [6:0]            dec_seg;

    seg_hex_decode u_dec (
        .hex_i   (cur_digit),
        .seg_n_o (dec_seg)
    );

    always_comb begin
        slot_end = (cnt_q == CNT_W'(SLOT_CYCLES - 1));
        wrap     = slot_end && (idx_q == IDX_W'(N_DIGITS - 1));

        cnt_d = slot_end ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end

        state_d = state_q;
        case (state_q)
            BLANK:   if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) state_d = DRIVE;
            DRIVE:   if (slot_end) state_d = BLANK;
            default: state_d = BLANK;
        endcase
    end

    // A load on the wrap cycle goes straight to the display and discards
    // whatever was pending, so the newest value always wins.
    always_comb begin
        pend_val_d  = pend_val_q;
        pend_dp_d   = pend_dp_q;
        pend_lz_d   = pend_lz_q;
        pend_flag_d = pend_flag_q;
        disp_val_d  = disp_val_q;
        disp_dp_d   = disp_dp_q;
        disp_lz_d   = disp_lz_q;
        if (wrap) begin
            if (load) begin
                disp_val_d = value;
                disp_dp_d  = dp_in;
                disp_lz_d  = lz_en;
            end else if (pend_flag_q) begin
                disp_val_d = pend_val_q;
                disp_dp_d  = pend_dp_q;
                disp_lz_d  = pend_lz_q;
            end
            pend_flag_d = 1'b0;
        end else if (load) begin
            pend_val_d  = value;
            pend_dp_d   = dp_in;
            pend_lz_d   = lz_en;
            pend_flag_d = 1'b1;
        end
    end

    always_comb begin
        cur_digit = 4'h0;
        cur_dp    = 1'b0;
        an_sel    = '1;
        for (int i = 0; i < int'(N_DIGITS); i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_digit = disp_val_q[4*i +: 4];
                cur_dp    = disp_dp_q[i];
                an_sel[i] = 1'b0;
            end
        end

        // Blank this digit if it and every more-significant digit are zero.
        suppress = disp_lz_q && (idx_q != '0);
        for (int i = 0; i < int'(N_DIGITS); i++) begin
            if ((IDX_W'(i) >= idx_q) && (disp_val_q[4*i +: 4] != 4'h0)) begin
                suppress = 1'b0;
            end
        end

        an_d  = '1;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        if (state_q == DRIVE) begin
            an_d  = an_sel;
            seg_d = suppress ? SEG_BLANK : dec_seg;
            dp_d  = ~cur_dp;
        end
        tick_d = wrap;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= BLANK;
            cnt_q       <= '0;
            idx_q       <= '0;
            pend_val_q  <= '0;
            pend_dp_q   <= '0;
            pend_lz_q   <= 1'b0;
            pend_flag_q <= 1'b0;
            disp_val_q  <= '0;
            disp_dp_q   <= '0;
            disp_lz_q   <= 1'b0;
            an_q        <= '1;
            seg_q       <= SEG_BLANK;
            dp_q        <= 1'b1;
            tick_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            pend_val_q  <= pend_val_d;
            pend_dp_q   <= pend_dp_d;
            pend_lz_q   <= pend_lz_d;
            pend_flag_q <= pend_flag_d;
            disp_val_q  <= disp_val_d;
            disp_dp_q   <= disp_dp_d;
            disp_lz_q   <= disp_lz_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            tick_q      <= tick_d;
        end
    end

    assign an_n       = an_q;
    assign seg_n      = seg_q;
    assign dp_n       = dp_q;
    assign frame_tick = tick_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Directed bench for seven_segment_scanner with a 4-digit, 4-cycle-slot, 1-cycle-blank setup.
module tb_seven_segment_scanner;
    import seg_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        lz_en;
    logic        load;
    logic [3:0]  an_n;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic        frame_tick;
    scan_state_e dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] cap_an[4];
    logic [6:0] cap_seg[4];
    logic       cap_dp[4];
    logic [3:0] cap_blk_an[4];
    logic [6:0] cap_blk_seg[4];

    seven_segment_scanner #(
        .N_DIGITS     (4),
        .SLOT_CYCLES  (4),
        .BLANK_CYCLES (1),
        .CNT_W        (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value      (value),
        .dp_in      (dp_in),
        .lz_en      (lz_en),
        .load       (load),
        .an_n       (an_n),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .frame_tick (frame_tick),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- drivers ----------------
    task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic lz);
        value = v;
        dp_in = dp;
        lz_en = lz;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Called on the frame_tick cycle; samples the blank and mid-drive cycle of each digit.
    task automatic capture_frame(input bit mid_load, input logic [15:0] mv);
        for (int off = 1; off <= 15; off++) begin
            @(negedge clk);
            if (off % 4 == 1) begin
                cap_blk_an[off/4]  = an_n;
                cap_blk_seg[off/4] = seg_n;
            end
            if (off % 4 == 3) begin
                cap_an[off/4]  = an_n;
                cap_seg[off/4] = seg_n;
                cap_dp[off/4]  = dp_n;
            end
            if (mid_load && off == 5) begin
                value = mv;
                dp_in = 4'b0000;
                lz_en = 1'b0;
                load  = 1'b1;
            end
            if (off == 6) load = 1'b0;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int first_gap;
        int second_gap;
        rst_n = 1'b0;
        value = '0;
        dp_in = '0;
        lz_en = 1'b0;
        load  = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (an_n !== 4'b1111) begin n_fail++; $display("FAIL reset_an: got %b expected 1111", an_n); end
        n_checks++;
        if (seg_n !== 7'b1111111) begin n_fail++; $display("FAIL reset_seg: got %b expected 1111111", seg_n); end
        n_checks++;
        if (dp_n !== 1'b1) begin n_fail++; $display("FAIL reset_dp: got %b expected 1", dp_n); end
        n_checks++;
        if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b expected 0", frame_tick); end

        rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            logic [3:0] ea;
            logic [6:0] es;
            @(negedge clk);
            ea = (k == 1 || k == 5) ? 4'b1111 : 4'b1110;
            es = (k == 1 || k == 5) ? 7'b1111111 : 7'b1000000;
            n_checks++;
            if (an_n !== ea || seg_n !== es) begin
                n_fail++;
                $display("FAIL idle_cycle%0d: got an=%b seg=%b expected an=%b seg=%b", k, an_n, seg_n, ea, es);
            end
        end

        first_gap = -1;
        for (int i = 6; i <= 40; i++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) begin first_gap = i; break; end
        end
        n_checks++;
        if (first_gap != 16) begin n_fail++; $display("FAIL first_tick: got cycle %0d expected 16", first_gap); end
        n_checks++;
        if (an_n !== 4'b0111) begin n_fail++; $display("FAIL tick_align_an: got %b expected 0111", an_n); end

        second_gap = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) begin second_gap = i; break; end
        end
        n_checks++;
        if (second_gap != 16) begin n_fail++; $display("FAIL tick_period: got %0d expected 16", second_gap); end
    endtask

    task automatic test_value();
        bit ok;
        logic [6:0] es[4];
        es[0] = 7'b1000000; es[1] = 7'b0001110; es[2] = 7'b1111001; es[3] = 7'b0001000;
        do_load(16'hA1F0, 4'b0000, 1'b0);
        wait_tick(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL value_tick: got no frame_tick expected one within 40 cycles"); end
        capture_frame(1'b0, 16'h0);
        for (int d = 0; d < 4; d++) begin
            logic [3:0] ea;
            ea = 4'b1111;
            ea[d] = 1'b0;
            n_checks++;
            if (cap_an[d] !== ea || cap_seg[d] !== es[d] || cap_dp[d] !== 1'b1) begin
                n_fail++;
                $display("FAIL value_digit%0d: got an=%b seg=%b dp=%b expected an=%b seg=%b dp=1",
                         d, cap_an[d], cap_seg[d], cap_dp[d], ea, es[d]);
            end
            n_checks++;
            if (cap_blk_an[d] !== 4'b1111 || cap_blk_seg[d] !== 7'b1111111) begin
                n_fail++;
                $display("FAIL value_blank%0d: got an=%b seg=%b expected an=1111 seg=1111111",
                         d, cap_blk_an[d], cap_blk_seg[d]);
            end
        end
    endtask

    task automatic test_tearing();
        bit ok;
        logic [6:0] es[4];
        es[0] = 7'b1000000; es[1] = 7'b0001110; es[2] = 7'b1111001; es[3] = 7'b0001000;
        wait_tick(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL tear_tick1: got no frame_tick expected one"); end
        capture_frame(1'b1, 16'h1111);
        for (int d = 0; d < 4; d++) begin
            n_checks++;
            if (cap_seg[d] !== es[d]) begin
                n_fail++;
                $display("FAIL tear_old%0d: got seg=%b expected %b", d, cap_seg[d], es[d]);
            end
        end
        wait_tick(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL tear_tick2: got no frame_tick expected one"); end
        capture_frame(1'b0, 16'h0);
        for (int d = 0; d < 4; d++) begin
            n_checks++;
            if (cap_seg[d] !== 7'b1111001) begin
                n_fail++;
                $display("FAIL tear_new%0d: got seg=%b expected 1111001", d, cap_seg[d]);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        wait_tick(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL b2b_tick: got no frame_tick expected one"); end
        capture_frame(1'b1, 16'h3333);
        // Now on the wrap cycle: this load must bypass the pending 3333.
        value = 16'h2222;
        dp_in = 4'b0000;
        lz_en = 1'b0;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        n_checks++;
        if (frame_tick !== 1'b1) begin n_fail++; $display("FAIL b2b_wrap_align: got tick=%b expected 1", frame_tick); end
        for (int f = 0; f < 2; f++) begin
            if (f == 1) begin
                wait_tick(ok);
                n_checks++;
                if (!ok) begin n_fail++; $display("FAIL b2b_tick2: got no frame_tick expected one"); end
            end
            capture_frame(1'b0, 16'h0);
            for (int d = 0; d < 4; d++) begin
                n_checks++;
                if (cap_seg[d] !== 7'b0100100) begin
                    n_fail++;
                    $display("FAIL b2b_frame%0d_digit%0d: got seg=%b expected 0100100", f, d, cap_seg[d]);
                end
            end
        end
    endtask

    task automatic test_lz();
        bit ok;
        logic [6:0] es[4];
        logic       edp[4];
        es[0] = 7'b1000000; es[1] = 7'b0010010; es[2] = 7'b1111111; es[3] = 7'b1111111;
        edp[0] = 1'b1; edp[1] = 1'b1; edp[2] = 1'b1; edp[3] = 1'b0;
        do_load(16'h0050, 4'b1000, 1'b1);
        wait_tick(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL lz_tick: got no frame_tick expected one"); end
        capture_frame(1'b0, 16'h0);
        for (int d = 0; d < 4; d++) begin
            logic [3:0] ea;
            ea = 4'b1111;
            ea[d] = 1'b0;
            n_checks++;
            if (cap_an[d] !== ea || cap_seg[d] !== es[d] || cap_dp[d] !== edp[d]) begin
                n_fail++;
                $display("FAIL lz_digit%0d: got an=%b seg=%b dp=%b expected an=%b seg=%b dp=%b",
                         d, cap_an[d], cap_seg[d], cap_dp[d], ea, es[d], edp[d]);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        wait_tick(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL rmid_tick: got no frame_tick expected one"); end
        for (int off = 1; off <= 10; off++) begin
            @(negedge clk);
            if (off == 5) begin
                value = 16'h7777;
                dp_in = 4'b1111;
                lz_en = 1'b0;
                load  = 1'b1;
            end
            if (off == 6) load = 1'b0;
        end
        n_checks++;
        if (an_n !== 4'b1011) begin n_fail++; $display("FAIL rmid_pre_an: got %b expected 1011", an_n); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (an_n !== 4'b1111 || seg_n !== 7'b1111111 || dp_n !== 1'b1 || frame_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_async: got an=%b seg=%b dp=%b tick=%b expected 1111 1111111 1 0",
                     an_n, seg_n, dp_n, frame_tick);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            logic [3:0] ea;
            logic [6:0] es;
            @(negedge clk);
            ea = (k == 1 || k == 5) ? 4'b1111 : 4'b1110;
            es = (k == 1 || k == 5) ? 7'b1111111 : 7'b1000000;
            n_checks++;
            if (an_n !== ea || seg_n !== es) begin
                n_fail++;
                $display("FAIL rmid_restart%0d: got an=%b seg=%b expected an=%b seg=%b", k, an_n, seg_n, ea, es);
            end
        end
        wait_tick(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL rmid_tick2: got no frame_tick expected one"); end
        capture_frame(1'b0, 16'h0);
        for (int d = 0; d < 4; d++) begin
            n_checks++;
            if (cap_seg[d] !== 7'b1000000 || cap_dp[d] !== 1'b1) begin
                n_fail++;
                $display("FAIL rmid_lost_pending%0d: got seg=%b dp=%b expected seg=1000000 dp=1",
                         d, cap_seg[d], cap_dp[d]);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst_n = 1'b0;
        value = '0;
        dp_in = '0;
        lz_en = 1'b0;
        load  = 1'b0;
        test_reset();
        test_value();
        test_tearing();
        test_back_to_back();
        test_lz();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seven_segment_scanner.md
Name: seven_segment_scanner

Overview:
- Time-multiplexes one hex-to-seven-segment decode path across N_DIGITS common-anode digits of a board display.
- Latches a packed hex value, then scans digits with a fixed per-digit slot and an anti-ghosting blank phase.
- New data is committed only at frame boundaries, so a frame never shows a mix of old and new digits.
- Sits between user logic, which supplies the value and a load strobe, and the board pins. All pin outputs are active-low.

Parameters:
- N_DIGITS, 4: number of multiplexed digits, range 2..8.
- SLOT_CYCLES, 50000: clk cycles per digit slot, including the blank phase; must be >= BLANK_CYCLES+1.
- BLANK_CYCLES, 500: cycles at the start of each slot with all anodes and segments off; must be >= 1.
- CNT_W, 16: width of the slot counter; must satisfy 2^CNT_W >= SLOT_CYCLES.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- value  in  4*N_DIGITS  hex digits; digit i = value[4i+3:4i], digit 0 is rightmost.
- dp_in  in  N_DIGITS  decimal point per digit, 1 = lit.
- lz_en  in  1  leading-zero suppression enable; sampled with value.
- load  in  1  1-cycle strobe; captures value, dp_in and lz_en into the pending buffer.
- an_n  out  N_DIGITS  digit anodes, 0 = digit enabled.
- seg_n  out  7  segments g..a in bits [6:0], 0 = lit.
- dp_n  out  1  decimal point, 0 = lit.
- frame_tick  out  1  1-cycle pulse when the scan wraps from digit N_DIGITS-1 to digit 0.

Behaviour:
- Reset (rst_n=0, asynchronous) sets:
  - an_n all 1, seg_n 7'b1111111, dp_n 1, frame_tick 0.
  - State BLANK, digit index 0, slot counter 0.
  - Display and pending buffers 0; pending flag 0.
- Deassertion of rst_n is synchronized externally. The first BLANK phase starts on the first clk edge after release.
- Slot counter cnt runs 0..SLOT_CYCLES-1, then wraps to 0 and increments the digit index modulo N_DIGITS.
- FSM has 2 states:
  - BLANK while cnt < BLANK_CYCLES; DRIVE otherwise.
  - BLANK -> DRIVE when cnt == BLANK_CYCLES-1.
  - DRIVE -> BLANK when cnt == SLOT_CYCLES-1.
- Outputs are registered, with 1 cycle of latency from state/index to pins.
  - In BLANK: an_n all 1, seg_n all 1, dp_n 1.
  - In DRIVE: only an_n[idx]=0; seg_n = decode(display digit idx); dp_n = ~display_dp[idx].
- Load handling:
  - load=1 copies the inputs into pending and sets the pending flag.
  - A second load before commit overwrites pending (last load wins).
- Commit happens on the cycle where cnt==SLOT_CYCLES-1 and idx==N_DIGITS-1 (frame wrap).
  - If the pending flag is set, pending is copied to display and the flag is cleared.
  - If load is also high in that same cycle, the load inputs bypass pending and go straight to display, and the flag ends at 0.
- frame_tick is registered; it is high for exactly the first cycle of digit 0's BLANK phase after every wrap.
- Leading-zero suppression (display lz flag=1):
  - Digit i is blanked (seg_n all 1, anode still driven) when i > 0 and every display digit j >= i is 0.
  - Digit 0 is never suppressed.
  - A suppressed digit still shows its dp if that dp is set.
- Decode table (seg_n, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Reset mid-slot: outputs go to the reset values immediately (asynchronous) and the pending load is lost.

Decomposition:
- Shared package seg_pkg:
  - SEG_BLANK=7'b1111111 constant.
  - Scanner state enum {BLANK, DRIVE}.
  - The 16-entry active-low decode constants.
- One sub-module, seg_hex_decode: combinational 4-bit in, 7-bit active-low out, per the table above.
- The scanner instantiates seg_hex_decode once.

Test Plan (N_DIGITS=4, SLOT_CYCLES=4, BLANK_CYCLES=1):
- Reset then idle:
  - an_n=1111 and seg_n=1111111 during reset.
  - After release, each digit is blank for 1 cycle, then shows 1000000 for 3 cycles.
  - frame_tick pulses every 16 cycles.
- load value=16'hA1F0, dp_in=0, lz_en=0, then wait for commit:
  - an_n=1110 with seg_n=1000000.
  - an_n=1101 with seg_n=0001110.
  - an_n=1011 with seg_n=1111001.
  - an_n=0111 with seg_n=0001000.
- Tearing check: load 16'h1111 mid-frame:
  - The current frame still shows the old value on all 4 digits.
  - The new value appears from the frame after the next frame_tick.
- Load coincident with commit: load=16'h2222 on the wrap cycle while pending holds 16'h3333 -> the next frame shows 2 on all digits.
- lz_en=1, value=16'h0050, dp_in=4'b1000:
  - Digit 0 shows 1000000; digit 1 shows 0010010; digit 2 is blanked.
  - Digit 3 has segments blank but dp_n=0.
- Assert rst_n=0 during digit 2's DRIVE phase:
  - an_n, seg_n and dp_n go all-1 in the same cycle, with no clk edge needed.
  - After release, the scan restarts at digit 0 and displays 0.
